// File: rtl/note_scroller.sv
// note_scroller: generates LFSR notes, scrolls a 4-row lane once per beat,
// and runs the check_go/check_done handshake with the hit checker.
module note_scroller #(
   parameter int         BEAT_DIV   = 25_000_000,
   parameter int         SCORE_W    = 8,
   parameter logic [3:0] MAX_MISSES = 4'd8,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic               check_done,
   input  logic               hit,
   input  logic               miss,
   output logic               check_go,
   output logic [2:0]         row_1,
   output logic [2:0]         row_2,
   output logic [2:0]         row_3,
   output logic [2:0]         row_4,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         combo,
   output logic [3:0]         misses,
   output logic               game_over
);

   localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_BEAT, SHIFT, CHECK, RELEASE, OVER
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] beat_cnt;
   logic [7:0]       lfsr;
   logic [2:0]       note;
   logic             armed;
   logic             beat_end;
   logic             sample;
   logic             take_hit;
   logic             take_miss;
   logic             go_d;
   logic             over_d;

   assign beat_end  = (beat_cnt == CNT_LAST);
   assign note      = (lfsr[2:0] <= 3'b100) ? lfsr[2:0] : 3'b000;
   // stale check_done on the first CHECK cycle is ignored via armed
   assign sample    = (state == CHECK) && armed && check_done;
   assign take_hit  = hit & ~miss;
   assign take_miss = miss | (~hit & (row_4 != 3'b000));

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (enable) state_n = WAIT_BEAT;
         WAIT_BEAT: if (enable && beat_end) state_n = SHIFT;
         SHIFT:     state_n = CHECK;
         CHECK:     if (sample) state_n = RELEASE;
         RELEASE:   state_n = (misses == MAX_MISSES) ? OVER : WAIT_BEAT;
         OVER:      state_n = OVER;
         default:   state_n = IDLE;
      endcase
   end

   // output decode, registered below so outputs track the state register
   always_comb begin
      go_d   = (state_n == CHECK);
      over_d = (state_n == OVER);
   end

   // registered handshake and status outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         check_go  <= 1'b0;
         game_over <= 1'b0;
         armed     <= 1'b0;
      end else begin
         check_go  <= go_d;
         game_over <= over_d;
         armed     <= (state == CHECK);
      end
   end

   // beat counter: runs only in WAIT_BEAT while enabled
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt <= '0;
      end else if (state == WAIT_BEAT && enable) begin
         if (beat_end) beat_cnt <= '0;
         else          beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // lane scroll and note generation on each beat
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_1 <= 3'b000;
         row_2 <= 3'b000;
         row_3 <= 3'b000;
         row_4 <= 3'b000;
         lfsr  <= LFSR_SEED;
      end else if (state == SHIFT) begin
         row_4 <= row_3;
         row_3 <= row_2;
         row_2 <= row_1;
         row_1 <= note;
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   // scoring of the checker verdict for the bottom row
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         score  <= '0;
         combo  <= 8'd0;
         misses <= 4'd0;
      end else if (sample) begin
         if (take_hit) begin
            if (score != '1)     score <= score + 1'b1;
            if (combo != 8'hFF)  combo <= combo + 8'd1;
         end else if (take_miss) begin
            if (misses != 4'hF)  misses <= misses + 4'd1;
            combo <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_note_scroller.sv
// tb_note_scroller: directed plus randomized checks of note_scroller
// against a spec-level lane/score model and a checker responder.
module tb_note_scroller;

   localparam int         BD   = 4;
   localparam int         SMAX = 255;
   localparam logic [3:0] MAXM = 4'd8;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       check_done;
   logic       hit;
   logic       miss;
   logic       check_go;
   logic [2:0] row_1, row_2, row_3, row_4;
   logic [7:0] score;
   logic [7:0] combo;
   logic [3:0] misses;
   logic       game_over;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   logic go_q = 1'b0;

   logic [7:0] m_lfsr;
   logic [2:0] m_r1, m_r2, m_r3, m_r4;
   int m_score, m_combo, m_misses;

   note_scroller #(
      .BEAT_DIV(BD), .SCORE_W(8), .MAX_MISSES(MAXM), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .check_done(check_done), .hit(hit), .miss(miss),
      .check_go(check_go),
      .row_1(row_1), .row_2(row_2), .row_3(row_3), .row_4(row_4),
      .score(score), .combo(combo), .misses(misses),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // counts check_go rising edges
   always @(posedge clk) begin
      go_q <= check_go;
      if (check_go && !go_q) pulses <= pulses + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [2:0] note_of(input logic [7:0] l);
      return (l[2:0] <= 3'd4) ? l[2:0] : 3'd0;
   endfunction

   function automatic logic [11:0] m_rows();
      return {m_r1, m_r2, m_r3, m_r4};
   endfunction

   task automatic model_reset();
      m_lfsr = 8'hA5;
      m_r1 = 0; m_r2 = 0; m_r3 = 0; m_r4 = 0;
      m_score = 0; m_combo = 0; m_misses = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_go"}, 32'(check_go), 0);
      chk({tag, "_rows"}, 32'({row_1, row_2, row_3, row_4}), 0);
      chk({tag, "_cnts"}, 32'({score, combo, misses}), 0);
      chk({tag, "_over"}, 32'(game_over), 0);
   endtask

   task automatic apply_reset(input string tag);
      resetn = 1'b0;
      #2;
      check_zero(tag);
      tick();
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic wait_go(output bit ok);
      int n;
      n = 0;
      while (check_go !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      ok = (check_go === 1'b1);
      chk("go_rise", 32'(check_go), 1);
   endtask

   task automatic finish_beat(input logic h, input logic m, input int dly,
                              input bit stale, input bit drop_en);
      int n;
      m_r4 = m_r3; m_r3 = m_r2; m_r2 = m_r1;
      m_r1 = note_of(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
      chk("rows", 32'({row_1, row_2, row_3, row_4}), 32'(m_rows()));
      if (drop_en) enable = 1'b0;
      if (stale) begin
         check_done = 1'b1; hit = h; miss = m;
         tick();
         chk("stale_go", 32'(check_go), 1);
         chk("stale_score", 32'({score, combo, misses}),
             32'({8'(m_score), 8'(m_combo), 4'(m_misses)}));
         check_done = 1'b0; hit = 1'b0; miss = 1'b0;
      end
      repeat (dly) tick();
      check_done = 1'b1; hit = h; miss = m;
      n = 0;
      while (check_go !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check_done = 1'b0; hit = 1'b0; miss = 1'b0;
      chk("go_fall", 32'(check_go), 0);
      if (h && !m) begin
         if (m_score < SMAX) m_score++;
         if (m_combo < 255) m_combo++;
      end else if (m || m_r4 != 3'd0) begin
         m_misses++;
         m_combo = 0;
      end
      chk("score", 32'(score), m_score);
      chk("combo", 32'(combo), m_combo);
      chk("misses", 32'(misses), m_misses);
   endtask

   task automatic do_beat(input logic h, input logic m, input int dly,
                          input bit stale, input bit drop_en);
      bit ok;
      wait_go(ok);
      if (ok) finish_beat(h, m, dly, stale, drop_en);
   endtask

   initial begin
      bit ok;
      bit found;
      int p0, s0, c0, x0, edges, r;
      resetn = 1'b0; enable = 1'b0;
      check_done = 1'b0; hit = 1'b0; miss = 1'b0;
      model_reset();
      repeat (3) tick();
      check_zero("reset");
      resetn = 1'b1;
      repeat (10) tick();
      chk("idle_hold", 32'(check_go), 0);

      // scroll: four silent beats, one with stale check_done
      enable = 1'b1;
      p0 = pulses;
      for (int b = 0; b < 4; b++) do_beat(0, 0, 2, b == 1, 0);
      chk("pulses4", pulses - p0, 4);

      // hit on a key2 note
      found = 0;
      for (int b = 0; b < 200 && !found; b++) begin
         if (m_r3 == 3'b010) begin
            s0 = m_score; c0 = m_combo; x0 = m_misses;
            do_beat(1, 0, 1, 0, 0);
            chk("t3_score", 32'(score), s0 + 1);
            chk("t3_combo", 32'(combo), c0 + 1);
            chk("t3_misses", 32'(misses), x0);
            found = 1;
         end else if (m_r3 == 3'b000) do_beat(0, 0, 2, 0, 0);
         else do_beat(1, 0, 0, 0, 0);
      end
      chk("t3_found", 32'(found), 1);

      // silent miss on a key1 note
      found = 0;
      for (int b = 0; b < 200 && !found; b++) begin
         if (m_r3 == 3'b011) begin
            x0 = m_misses;
            do_beat(0, 0, 2, 0, 0);
            chk("t4_misses", 32'(misses), x0 + 1);
            chk("t4_combo", 32'(combo), 0);
            found = 1;
         end else if (m_r3 == 3'b000) do_beat(0, 0, 2, 0, 0);
         else do_beat(1, 0, 0, 0, 0);
      end
      chk("t4_found", 32'(found), 1);

      // randomized verdicts and checker latency
      for (int b = 0; b < 40 && m_misses < int'(MAXM); b++) begin
         r = $urandom_range(0, 3);
         do_beat(r == 1 || r == 3, r == 2 || r == 3,
                 $urandom_range(0, 3), 0, 0);
      end

      // async reset in the middle of CHECK
      apply_reset("rst_idle");
      enable = 1'b1;
      wait_go(ok);
      apply_reset("rst_mid_check");

      // score and combo saturation
      enable = 1'b1;
      for (int b = 0; b < 258; b++) do_beat(1, 0, 0, 0, 0);
      chk("sat_score", 32'(score), 255);
      chk("sat_combo", 32'(combo), 255);

      // pause in WAIT_BEAT stretches the beat by the paused cycles
      edges = 0;
      repeat (2) begin tick(); edges++; end
      enable = 1'b0;
      repeat (10) begin tick(); edges++; end
      chk("pause_rows", 32'({check_go, row_1, row_2, row_3, row_4}),
          32'({1'b0, m_rows()}));
      enable = 1'b1;
      while (check_go !== 1'b1 && edges < 60) begin tick(); edges++; end
      chk("pause_len", edges, BD + 2 + 10);
      if (check_go === 1'b1) finish_beat(1, 0, 1, 0, 0);

      // enable dropped during CHECK: handshake completes then holds
      do_beat(1, 0, 1, 0, 1);
      p0 = pulses;
      repeat (12) tick();
      chk("hold_pulses", pulses - p0, 0);
      chk("hold_rows", 32'({row_1, row_2, row_3, row_4}), 32'(m_rows()));
      enable = 1'b1;

      // game over after MAX_MISSES misses
      for (int b = 0; b < 20 && m_misses < int'(MAXM); b++) begin
         do_beat(0, 1, $urandom_range(0, 2), 0, 0);
         chk("over_lo", 32'(game_over), 0);
      end
      tick();
      chk("over_hi", 32'(game_over), 1);
      p0 = pulses;
      repeat (20) tick();
      chk("over_pulses", pulses - p0, 0);
      chk("over_rows", 32'({check_go, row_1, row_2, row_3, row_4}),
          32'({1'b0, m_rows()}));
      chk("over_misses", 32'(misses), 32'(MAXM));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
